// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit with a single-outstanding valid/ready
// request/response port to instruction memory and a prefetch FIFO toward decode.
// It owns the fetch PC, sequential increment, redirect flush, fetch-fault
// reporting and halt gating of new requests.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_valid/ready     fetch request handshake
//   imem_req_addr            word-aligned fetch address
//   imem_rsp_valid           one response per accepted request
//   imem_rsp_data            fetched instruction
//   imem_rsp_err             access fault on this response
//   redirect_valid/pc        flush the FIFO and refetch from redirect_pc
//   halt                     level; suppresses new requests while high
//   inst_valid/ready         FIFO head handshake toward decode
//   inst, inst_pc, inst_err  FIFO head fields (inst = 0 on a fault)
//   idle                     no response outstanding and FIFO empty
module ifu_prefetch #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      ILEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  output logic            idle
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX0    = '0;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD, S_STOP} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            stop_after_discard;
  logic            req_held;

  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [ILEN-1:0] q_inst [DEPTH];
  logic            q_err  [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;

  logic [AW:0]     count;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            accept;
  logic            pop;
  logic            redir_misaligned;
  logic            redir_inflight;

  always_comb begin
    count  = wr_ptr - rd_ptr;
    wr_idx = wr_ptr[AW-1:0];
    rd_idx = rd_ptr[AW-1:0];

    // A request that was presented but not yet taken stays up even if halt
    // rises or the slot check would now fail; only redirect retargets it.
    imem_req_valid = !rst && (state == S_REQ) &&
                     (req_held || (!halt && (count < DEPTH_C)));
    imem_req_addr  = fetch_pc;
    accept         = imem_req_valid && imem_req_ready;

    inst_valid = !rst && (count != '0);
    inst       = inst_valid ? q_inst[rd_idx] : '0;
    inst_pc    = inst_valid ? q_pc[rd_idx]   : '0;
    inst_err   = inst_valid && q_err[rd_idx];
    pop        = inst_valid && inst_ready && !redirect_valid;

    idle = rst || ((state != S_WAIT) && (state != S_DISCARD) && (count == '0));

    redir_misaligned = (redirect_pc[1:0] != 2'b00);
    // A response is still owed by memory after this edge: either one was
    // accepted right now, or we are waiting and it has not arrived yet.
    redir_inflight   = accept ||
                       (((state == S_WAIT) || (state == S_DISCARD)) && !imem_rsp_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_REQ;
      fetch_pc           <= RESET_PC;
      req_pc             <= '0;
      stop_after_discard <= 1'b0;
      req_held           <= 1'b0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc[AW'(i)]   <= '0;
        q_inst[AW'(i)] <= '0;
        q_err[AW'(i)]  <= 1'b0;
      end
    end else begin
      req_held <= imem_req_valid && !imem_req_ready && !redirect_valid;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        if (redir_misaligned) begin
          // Flush and leave exactly one fault entry for the bad target.
          q_pc[IDX0]         <= redirect_pc;
          q_inst[IDX0]       <= '0;
          q_err[IDX0]        <= 1'b1;
          wr_ptr             <= (AW+1)'(1);
          state              <= redir_inflight ? S_DISCARD : S_STOP;
          stop_after_discard <= redir_inflight;
        end else begin
          wr_ptr             <= '0;
          state              <= redir_inflight ? S_DISCARD : S_REQ;
          stop_after_discard <= 1'b0;
        end
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + (AW+1)'(1);
        end
        case (state)
          S_REQ: begin
            if (accept) begin
              req_pc   <= fetch_pc;
              fetch_pc <= fetch_pc + XLEN'(4);
              state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              q_pc[wr_idx]   <= req_pc;
              q_inst[wr_idx] <= imem_rsp_err ? '0 : imem_rsp_data;
              q_err[wr_idx]  <= imem_rsp_err;
              wr_ptr         <= wr_ptr + (AW+1)'(1);
              state          <= imem_rsp_err ? S_STOP : S_REQ;
            end
          end
          S_DISCARD: begin
            if (imem_rsp_valid) begin
              state              <= stop_after_discard ? S_STOP : S_REQ;
              stop_after_discard <= 1'b0;
            end
          end
          S_STOP: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Testbench for ifu_prefetch: directed scenarios followed by randomized
// traffic, checked against a transaction-level model of the fetch stream
// (expected PC sequence, FIFO occupancy, outstanding-response tracking).
module tb_ifu_prefetch;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        idle;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .XLEN(32), .RESET_PC(32'h8000_0000), .DEPTH(DEPTH), .ILEN(32)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .idle(idle)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // stimulus knobs
  int unsigned rdy_pct, pop_pct, lat_min, lat_max;
  bit          halt_v;
  bit          rnd_faults;
  logic [31:0] flt_addr;

  // memory model
  bit          mem_busy;
  logic [31:0] mem_addr;
  int unsigned mem_delay;

  // reference model of the fetch unit
  int          occ;
  bit          outstanding;
  bit          rsp_live;
  bit          req_blocked;
  bit          prev_hold;
  logic [31:0] req_exp;
  logic [31:0] exp_pc;
  int unsigned cyc;
  int unsigned first_iv;
  logic [31:0] acc_q[$];
  logic [31:0] pop_q[$];

  function automatic bit fault(input logic [31:0] a);
    return (a == flt_addr) || (rnd_faults && (a[7:2] == 6'h13));
  endfunction

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    imem_rsp_err = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt = 1'b0; inst_ready = 1'b0; halt_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_err", {31'd0, inst_err}, 32'd0);
    mem_busy = 0; mem_delay = 0; mem_addr = '0;
    occ = 0; outstanding = 0; rsp_live = 0; req_blocked = 0; prev_hold = 0;
    req_exp = 32'h8000_0000; exp_pc = 32'h8000_0000;
    cyc = 1; first_iv = 0;
    acc_q.delete(); pop_q.delete();
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs at the negedge, check outputs, then
  // advance the model as if the coming posedge has happened.
  task automatic step(input bit rv, input logic [31:0] rpc);
    bit          rsp, acc, pop, e_err, mis;
    rsp = mem_busy && (mem_delay == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memdata(mem_addr) : 32'hDEAD_BEEF;
    imem_rsp_err   = rsp && fault(mem_addr);
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready     = ($urandom_range(99) < pop_pct);
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = halt_v;
    #1;
    chk("idle", {31'd0, idle}, {31'd0, (occ == 0) && !outstanding});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, occ != 0});
    chk("req_valid", {31'd0, imem_req_valid},
        {31'd0, prev_hold || (!outstanding && !req_blocked && !halt_v && (occ < DEPTH))});
    if (imem_req_valid) chk("req_addr", imem_req_addr, req_exp);
    if (inst_valid && first_iv == 0) first_iv = cyc;

    pop = inst_valid && inst_ready && !rv;
    if (pop) begin
      e_err = (exp_pc[1:0] != 2'b00) || fault(exp_pc);
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_err", {31'd0, inst_err}, {31'd0, e_err});
      chk("inst", inst, e_err ? 32'd0 : memdata(exp_pc));
      pop_q.push_back(inst_pc);
      exp_pc = exp_pc + 32'd4;
      occ--;
    end

    acc = imem_req_valid && imem_req_ready;
    if (rsp) begin
      mem_busy = 0;
      outstanding = 0;
      if (rsp_live && !rv) begin
        occ++;
        if (imem_rsp_err) req_blocked = 1;
      end
    end else if (mem_busy) begin
      mem_delay--;
    end
    if (acc) begin
      mem_busy = 1;
      mem_addr = imem_req_addr;
      mem_delay = $urandom_range(lat_max - 1, lat_min - 1);
      rsp_live = 1;
      outstanding = 1;
      acc_q.push_back(imem_req_addr);
      req_exp = req_exp + 32'd4;
    end
    prev_hold = imem_req_valid && !imem_req_ready && !rv;
    if (rv) begin
      mis = (rpc[1:0] != 2'b00);
      occ = mis ? 1 : 0;
      rsp_live = 0;
      req_exp = rpc;
      exp_pc = rpc;
      req_blocked = mis;
      prev_hold = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 32'd0);
  endtask

  initial begin
    int unsigned sz;
    logic [31:0] rpc;
    rst = 1'b1;
    rdy_pct = 100; pop_pct = 100; lat_min = 1; lat_max = 1;
    rnd_faults = 0; flt_addr = 32'h0000_0001;

    // Sequential fetch with a zero-wait memory.
    do_reset();
    run(12);
    chk("first_inst_valid_cycle", first_iv, 32'd3);
    chk("seq_addr0", acc_q.size() > 0 ? acc_q[0] : 32'hX, 32'h8000_0000);
    chk("seq_addr1", acc_q.size() > 1 ? acc_q[1] : 32'hX, 32'h8000_0004);
    chk("seq_addr2", acc_q.size() > 2 ? acc_q[2] : 32'hX, 32'h8000_0008);
    chk("seq_pop2", pop_q.size() > 2 ? pop_q[2] : 32'hX, 32'h8000_0008);

    // Decode stalled: FIFO fills, then one pop frees one request slot.
    do_reset();
    pop_pct = 0;
    run(20);
    chk("full_accepts", acc_q.size(), 32'd4);
    chk("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("full_idle", {31'd0, idle}, 32'd0);
    pop_pct = 100; run(1);
    pop_pct = 0;   run(10);
    chk("one_pop_one_req", acc_q.size(), 32'd5);

    // Redirect while waiting: late response dropped, FIFO flushed.
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 30 && acc_q.size() < 2; i++) run(1);
    chk("wait_two_accepts", acc_q.size(), 32'd2);
    step(1'b1, 32'h8000_1000);
    pop_pct = 100;
    run(15);
    chk("redirect_first_pc", pop_q.size() > 0 ? pop_q[0] : 32'hX, 32'h8000_1000);

    // Fetch fault stops issue until a redirect.
    do_reset();
    lat_min = 1; lat_max = 1; flt_addr = 32'h8000_0008;
    run(20);
    chk("fault_accepts", acc_q.size(), 32'd3);
    chk("fault_pops", pop_q.size(), 32'd3);
    step(1'b1, 32'h8000_0100);
    run(10);
    chk("fault_resume", acc_q.size() > 3 ? acc_q[3] : 32'hX, 32'h8000_0100);
    flt_addr = 32'h0000_0001;

    // Misaligned redirect: single fault entry, no memory access.
    do_reset();
    run(3);
    step(1'b1, 32'h8000_0102);
    sz = acc_q.size();
    run(10);
    chk("misalign_no_req", acc_q.size(), sz);
    chk("misalign_pc", pop_q.size() > 0 ? pop_q[pop_q.size()-1] : 32'hX, 32'h8000_0102);

    // Halt raised while waiting: response still lands, issue resumes at pc+4.
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && acc_q.size() < 1; i++) run(1);
    halt_v = 1'b1;
    run(10);
    chk("halt_accepts", acc_q.size(), 32'd1);
    chk("halt_pushed", pop_q.size(), 32'd1);
    halt_v = 1'b0;
    run(8);
    chk("halt_resume", acc_q.size() > 1 ? acc_q[1] : 32'hX, 32'h8000_0004);

    // Randomized traffic, including redirects near the top of the address space.
    do_reset();
    rnd_faults = 1;
    for (int unsigned i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        rdy_pct = $urandom_range(100, 20);
        pop_pct = $urandom_range(100, 10);
        lat_min = 1;
        lat_max = $urandom_range(4, 1);
      end
      if ($urandom_range(99) < 3) halt_v = ~halt_v;
      if ($urandom_range(99) < 3) begin
        case ($urandom_range(3))
          0:       rpc = 32'hFFFF_FFF0;
          1:       rpc = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
          default: rpc = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
        endcase
        step(1'b1, rpc);
      end else begin
        step(1'b0, 32'd0);
      end
    end
    chk("random_progress", {31'd0, pop_q.size() > 100}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised instruction fetch unit for the next-generation multi-cycle RV32 core. It replaces the combinational `pc` → `inst` path with two handshakes: a valid/ready request/response interface to instruction memory, and a prefetch FIFO feeding decode. It owns the fetch PC, sequential increment, redirect (branch/jump/trap) flush, fetch-error reporting and halt (ebreak) gating.

Parameters:
XLEN, 32, width of PC and addresses
RESET_PC, 32'h80000000, fetch PC loaded on reset
DEPTH, 4, prefetch FIFO entries; power of 2, >= 2
ILEN, 32, instruction width

Ports:
clk  in  1  clock
rst  in  1  reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address, word aligned
imem_rsp_valid  in  1  response valid; exactly one per accepted request, earliest the cycle after acceptance
imem_rsp_data  in  ILEN  fetched instruction
imem_rsp_err  in  1  access fault on this response
redirect_valid  in  1  flush and refetch
redirect_pc  in  XLEN  new fetch PC
halt  in  1  level; while high no new requests issue
inst_valid  out  1  FIFO head valid
inst_ready  in  1  decode consumes head
inst  out  ILEN  head instruction
inst_pc  out  XLEN  head PC
inst_err  out  1  head is a fetch fault; inst = 0
idle  out  1  state != WAIT/DISCARD and FIFO empty

Behaviour:
- Reset: clk and rst, reset synchronous, active-high. fetch_pc = RESET_PC, FIFO empty, state REQ, discard flag 0. Outputs during and after reset: imem_req_valid = 0 in the reset cycle; inst_valid = 0; inst, inst_pc, inst_err = 0; idle = 1.
- Reset mid-operation: any in-flight response arriving after reset is ignored; its arrival is the memory model's responsibility to suppress.
- States: REQ, WAIT, DISCARD, STOP.
- REQ:
  - imem_req_valid = !halt && (count + 0) < DEPTH, where count = FIFO occupancy. One outstanding request maximum.
  - imem_req_addr = fetch_pc.
  - Once asserted, valid and address hold until accepted. The only exception is redirect, which retargets the request.
  - On valid && ready: latch req_pc = fetch_pc, fetch_pc += 4 (wraps modulo 2^XLEN), go to WAIT.
- WAIT:
  - On rsp_valid: push {req_pc, rsp_data, rsp_err}.
  - If rsp_err: push with inst = 0, go to STOP. Otherwise go to REQ.
  - Push is guaranteed legal because the slot was reserved at issue.
- DISCARD: on rsp_valid, drop the response without pushing, go to REQ.
- STOP: no requests until redirect.
- Output side:
  - inst_valid = FIFO non-empty; head fields are driven directly from FIFO storage.
  - Pop on inst_valid && inst_ready.
  - Data pushed at edge N is visible on the outputs in cycle N+1.
  - Push and pop in the same cycle are allowed, including when the FIFO is full: the pop frees the slot, and the next issue is evaluated next cycle.
- Redirect (highest priority, takes effect at the clock edge):
  - The FIFO is flushed. Any pop in the same cycle is void; downstream must disregard inst that cycle.
  - fetch_pc = redirect_pc.
  - If state is WAIT without rsp_valid, or the request is accepted in this same cycle: go to DISCARD.
  - If state is WAIT with rsp_valid in the same cycle: the response is dropped, go to REQ.
  - Otherwise go to REQ.
  - A redirect with redirect_pc[1:0] != 0 issues no memory access. It pushes {redirect_pc, 0, err = 1}, then goes to STOP, or to DISCARD-then-STOP if a response is in flight.
- halt: gates new issue only. An in-flight response completes and is pushed. Deasserting halt resumes issue at fetch_pc.
- Throughput: one instruction per 2 cycles with a zero-wait-state memory.

Test Plan:
- Reset, then ready = 1, 1-cycle memory: requests at 0x80000000, 0x80000004, 0x80000008; inst_pc follows the same order; first inst_valid 3 cycles after rst falls.
- inst_ready = 0, DEPTH = 4: exactly 4 responses accepted, imem_req_valid = 0, idle = 0; one pop allows exactly one new request.
- Redirect to 0x80001000 while WAIT: the late response for 0x80000004 is dropped; the next inst_pc is 0x80001000; FIFO contents flushed.
- imem_rsp_err = 1 on 0x80000008: entry with inst_err = 1, inst = 0, pc 0x80000008; no further requests until redirect to 0x80000100, then fetch resumes there.
- Redirect to 0x80000102: entry err = 1, pc 0x80000102; no memory request issued.
- halt raised during WAIT: the response is still pushed, then imem_req_valid stays 0; halt drops and the next request is at pc + 4.
